// File: rtl/aclk_pkg.sv
// rtl/aclk_pkg.sv - shared BCD time constants, time struct and validity check
package aclk_pkg;

   localparam int DIGIT_W = 4;

   localparam logic [DIGIT_W-1:0] MAX_LS          = 4'd9;
   localparam logic [DIGIT_W-1:0] MAX_MS_MIN      = 4'd5;
   localparam logic [DIGIT_W-1:0] MAX_MS_HR       = 4'd2;
   localparam logic [DIGIT_W-1:0] MAX_LS_HR_AT_20 = 4'd3;

   typedef struct packed {
      logic [DIGIT_W-1:0] ms_hr;
      logic [DIGIT_W-1:0] ls_hr;
      logic [DIGIT_W-1:0] ms_min;
      logic [DIGIT_W-1:0] ls_min;
   } bcd_time_t;

   // Legal 24 h HH:MM; also used by the alarm-set path.
   function automatic logic time_valid(input bcd_time_t t);
      logic ok;
      ok = (t.ls_min <= MAX_LS) && (t.ms_min <= MAX_MS_MIN) &&
           (t.ls_hr <= MAX_LS) && (t.ms_hr <= MAX_MS_HR);
      if ((t.ms_hr == MAX_MS_HR) && (t.ls_hr > MAX_LS_HR_AT_20))
         ok = 1'b0;
      return ok;
   endfunction

endpackage

// File: rtl/aclk_time_counter_if.sv
// rtl/aclk_time_counter_if.sv - load/tick inputs and time/flag outputs of the time counter
interface aclk_time_counter_if;
   import aclk_pkg::*;

   logic               one_minute;
   logic               load_new_c;
   logic [DIGIT_W-1:0] new_current_time_ms_hr;
   logic [DIGIT_W-1:0] new_current_time_ls_hr;
   logic [DIGIT_W-1:0] new_current_time_ms_min;
   logic [DIGIT_W-1:0] new_current_time_ls_min;
   logic [DIGIT_W-1:0] current_time_ms_hr;
   logic [DIGIT_W-1:0] current_time_ls_hr;
   logic [DIGIT_W-1:0] current_time_ms_min;
   logic [DIGIT_W-1:0] current_time_ls_min;
   logic               day_wrap;
   logic               load_err;

   modport master (
      output one_minute, load_new_c,
             new_current_time_ms_hr, new_current_time_ls_hr,
             new_current_time_ms_min, new_current_time_ls_min,
      input  current_time_ms_hr, current_time_ls_hr,
             current_time_ms_min, current_time_ls_min,
             day_wrap, load_err
   );

   modport slave (
      input  one_minute, load_new_c,
             new_current_time_ms_hr, new_current_time_ls_hr,
             new_current_time_ms_min, new_current_time_ls_min,
      output current_time_ms_hr, current_time_ls_hr,
             current_time_ms_min, current_time_ls_min,
             day_wrap, load_err
   );

endinterface

// File: rtl/aclk_bcd_inc.sv
// rtl/aclk_bcd_inc.sv - combinational HH:MM + 1 minute with day wrap flag
module aclk_bcd_inc
   import aclk_pkg::*;
(
   input  bcd_time_t i_time,
   output bcd_time_t o_time,
   output logic      o_wrap
);

   // Ripple carry from minutes units up to hours tens; 23:59 folds back to 00:00.
   always_comb begin
      o_time = i_time;
      o_wrap = 1'b0;
      if (i_time.ls_min == MAX_LS) begin
         o_time.ls_min = '0;
         if (i_time.ms_min == MAX_MS_MIN) begin
            o_time.ms_min = '0;
            if ((i_time.ms_hr == MAX_MS_HR) && (i_time.ls_hr == MAX_LS_HR_AT_20)) begin
               o_time.ls_hr = '0;
               o_time.ms_hr = '0;
               o_wrap       = 1'b1;
            end else if (i_time.ls_hr == MAX_LS) begin
               o_time.ls_hr = '0;
               o_time.ms_hr = i_time.ms_hr + 4'd1;
            end else begin
               o_time.ls_hr = i_time.ls_hr + 4'd1;
            end
         end else begin
            o_time.ms_min = i_time.ms_min + 4'd1;
         end
      end else begin
         o_time.ls_min = i_time.ls_min + 4'd1;
      end
   end

endmodule

// File: rtl/aclk_time_counter.sv
// rtl/aclk_time_counter.sv - current time-of-day register with load, minute tick and pulse flags
module aclk_time_counter
   import aclk_pkg::*;
(
   input logic                clock,
   input logic                reset,
   aclk_time_counter_if.slave bus
);

   bcd_time_t r_time;
   logic      r_day_wrap;
   logic      r_load_err;

   bcd_time_t w_new_time;
   bcd_time_t w_inc_time;
   logic      w_inc_wrap;
   logic      w_new_valid;

   assign w_new_time.ms_hr  = bus.new_current_time_ms_hr;
   assign w_new_time.ls_hr  = bus.new_current_time_ls_hr;
   assign w_new_time.ms_min = bus.new_current_time_ms_min;
   assign w_new_time.ls_min = bus.new_current_time_ls_min;
   assign w_new_valid       = time_valid(w_new_time);

   aclk_bcd_inc u_inc (
      .i_time (r_time),
      .o_time (w_inc_time),
      .o_wrap (w_inc_wrap)
   );

   // Priority: reset, then load (which swallows a coincident tick even when rejected), then tick.
   always_ff @(posedge clock) begin
      if (!reset) begin
         r_time     <= '0;
         r_day_wrap <= 1'b0;
         r_load_err <= 1'b0;
      end else begin
         r_day_wrap <= 1'b0;
         r_load_err <= 1'b0;
         if (bus.load_new_c) begin
            if (w_new_valid)
               r_time <= w_new_time;
            else
               r_load_err <= 1'b1;
         end else if (bus.one_minute) begin
            r_time     <= w_inc_time;
            r_day_wrap <= w_inc_wrap;
         end
      end
   end

   assign bus.current_time_ms_hr  = r_time.ms_hr;
   assign bus.current_time_ls_hr  = r_time.ls_hr;
   assign bus.current_time_ms_min = r_time.ms_min;
   assign bus.current_time_ls_min = r_time.ls_min;
   assign bus.day_wrap            = r_day_wrap;
   assign bus.load_err            = r_load_err;

endmodule

// File: tb/tb_aclk_time_counter.sv
// tb/tb_aclk_time_counter.sv - randomized and directed bench for aclk_time_counter
module tb_aclk_time_counter;

   logic clock;
   logic reset;
   int   n_checks;
   int   n_pass;

   int   m_min;
   int   m_wrap;
   int   m_err;

   aclk_time_counter_if bus();

   aclk_time_counter dut (
      .clock (clock),
      .reset (reset),
      .bus   (bus.slave)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   task automatic check_eq(input string tag, input int got, input int exp);
      n_checks++;
      if (got == exp)
         n_pass++;
      else
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
   endtask

   function automatic logic [15:0] min_to_bcd(input int m);
      int hh;
      int mm;
      hh = m / 60;
      mm = m % 60;
      return {4'(hh / 10), 4'(hh % 10), 4'(mm / 10), 4'(mm % 10)};
   endfunction

   function automatic int bcd_ok(input logic [15:0] t);
      int hh;
      int mm;
      if (t[15:12] > 9 || t[11:8] > 9 || t[7:4] > 9 || t[3:0] > 9)
         return 0;
      hh = 10 * int'(t[15:12]) + int'(t[11:8]);
      mm = 10 * int'(t[7:4]) + int'(t[3:0]);
      return (hh < 24 && mm < 60) ? 1 : 0;
   endfunction

   function automatic int bcd_to_min(input logic [15:0] t);
      return 60 * (10 * int'(t[15:12]) + int'(t[11:8])) + 10 * int'(t[7:4]) + int'(t[3:0]);
   endfunction

   task automatic model_step(input logic rst_n, input logic tick, input logic ld,
                             input logic [15:0] nt);
      m_wrap = 0;
      m_err  = 0;
      if (!rst_n) begin
         m_min = 0;
      end else if (ld) begin
         if (bcd_ok(nt) == 1)
            m_min = bcd_to_min(nt);
         else
            m_err = 1;
      end else if (tick) begin
         m_min = (m_min + 1) % 1440;
         if (m_min == 0)
            m_wrap = 1;
      end
   endtask

   task automatic cycle(input logic rst_n, input logic tick, input logic ld,
                        input logic [15:0] nt);
      logic [15:0] got;
      reset                       = rst_n;
      bus.one_minute              = tick;
      bus.load_new_c              = ld;
      bus.new_current_time_ms_hr  = nt[15:12];
      bus.new_current_time_ls_hr  = nt[11:8];
      bus.new_current_time_ms_min = nt[7:4];
      bus.new_current_time_ls_min = nt[3:0];
      @(posedge clock);
      model_step(rst_n, tick, ld, nt);
      #1;
      got = {bus.current_time_ms_hr, bus.current_time_ls_hr,
             bus.current_time_ms_min, bus.current_time_ls_min};
      check_eq("time", int'(got), int'(min_to_bcd(m_min)));
      check_eq("day_wrap", int'(bus.day_wrap), m_wrap);
      check_eq("load_err", int'(bus.load_err), m_err);
      check_eq("range", bcd_ok(got), 1);
   endtask

   logic [15:0] rnd_t;
   int          wraps;

   initial begin
      n_checks = 0;
      n_pass   = 0;
      m_min    = 0;
      m_wrap   = 0;
      m_err    = 0;
      wraps    = 0;

      cycle(1'b0, 1'b0, 1'b0, 16'h0000);
      cycle(1'b1, 1'b0, 1'b0, 16'h0000);

      cycle(1'b1, 1'b0, 1'b1, 16'h1259);
      cycle(1'b1, 1'b1, 1'b0, 16'h0000);
      cycle(1'b1, 1'b0, 1'b1, 16'h0959);
      cycle(1'b1, 1'b1, 1'b0, 16'h0000);
      cycle(1'b1, 1'b0, 1'b1, 16'h2358);
      cycle(1'b1, 1'b1, 1'b0, 16'h0000);
      cycle(1'b1, 1'b1, 1'b0, 16'h0000);
      cycle(1'b1, 1'b0, 1'b0, 16'h0000);

      cycle(1'b1, 1'b0, 1'b1, 16'h1111);
      cycle(1'b1, 1'b0, 1'b1, 16'h2400);
      cycle(1'b1, 1'b0, 1'b1, 16'h1960);
      cycle(1'b1, 1'b0, 1'b1, 16'h0A00);
      cycle(1'b1, 1'b1, 1'b1, 16'h2400);
      cycle(1'b1, 1'b0, 1'b0, 16'h0000);

      cycle(1'b1, 1'b1, 1'b1, 16'h0730);
      cycle(1'b0, 1'b1, 1'b1, 16'h1545);
      cycle(1'b1, 1'b0, 1'b0, 16'h0000);

      for (int i = 0; i < 600; i++) begin
         logic r_rst;
         logic r_tick;
         logic r_ld;
         r_rst  = ($urandom_range(0, 63) != 0);
         r_tick = ($urandom_range(0, 1) == 1);
         r_ld   = ($urandom_range(0, 9) == 0);
         if ($urandom_range(0, 1) == 1)
            rnd_t = min_to_bcd(int'($urandom_range(0, 1439)));
         else
            rnd_t = 16'($urandom);
         cycle(r_rst, r_tick, r_ld, rnd_t);
      end

      cycle(1'b0, 1'b0, 1'b0, 16'h0000);
      for (int i = 0; i < 1440; i++) begin
         cycle(1'b1, 1'b1, 1'b0, 16'h0000);
         if (bus.day_wrap)
            wraps++;
      end
      check_eq("day_wraps", wraps, 1);
      cycle(1'b1, 1'b0, 1'b0, 16'h0000);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/aclk_time_counter.md
# aclk_time_counter

Holds the alarm clock's current time of day as four BCD digits in 24-hour format, HH:MM. It sits directly downstream of `aclk_timegen` and consumes its `one_minute` strobe to advance the time by one minute. It also accepts a synchronous load of a new time from the key path. Its outputs drive the display mux and the alarm comparator.

## Interface
- No parameters. The format is fixed at 24 h, BCD.

- `clock`  in  1  system clock, rising edge
- `reset`  in  1  synchronous, active-low reset, sampled on the rising edge of `clock`
- `one_minute`  in  1  minute strobe from `aclk_timegen`; every cycle it is high is one tick
- `load_new_c`  in  1  load request for the new current time
- `new_current_time_ms_hr`  in  4  new hours tens digit, BCD
- `new_current_time_ls_hr`  in  4  new hours units digit, BCD
- `new_current_time_ms_min`  in  4  new minutes tens digit, BCD
- `new_current_time_ls_min`  in  4  new minutes units digit, BCD
- `current_time_ms_hr`  out  4  hours tens digit, 0–2
- `current_time_ls_hr`  out  4  hours units digit, 0–9, limited to 0–3 when the tens digit is 2
- `current_time_ms_min`  out  4  minutes tens digit, 0–5
- `current_time_ls_min`  out  4  minutes units digit, 0–9
- `day_wrap`  out  1  one-cycle pulse when the time rolls from 23:59 to 00:00
- `load_err`  out  1  one-cycle pulse when a load request is rejected

## Operation
- All outputs are registered.
- On reset: all four digits = 0 (00:00), `day_wrap` = 0, `load_err` = 0.
- Priority per cycle: reset > `load_new_c` > `one_minute` > hold.
- **Load:** when `load_new_c` = 1, the new time is validated.
  - Valid means: every digit ≤ 9, ms_min ≤ 5, ms_hr ≤ 2, and if ms_hr = 2 then ls_hr ≤ 3.
  - Valid load: all four digits are replaced.
  - Invalid load: the time is unchanged and `load_err` = 1 for one cycle.
- **Load and tick in the same cycle:** the load wins and that tick is discarded, whether the load is valid or not. An invalid load therefore freezes the time for that minute.
- **Tick:** increment ls_min with ripple carry:
  - ls_min 9 → 0, carry into ms_min.
  - ms_min 5 → 0, carry into hours.
  - ls_hr 9 → 0, carry into ms_hr.
  - When the time is 23:59, the next tick gives 00:00 and `day_wrap` = 1 for one cycle.
- `day_wrap` and `load_err` are 0 in every cycle not described above.
- The block does not require `one_minute` to be a single-cycle strobe. If it is high for N consecutive cycles, the time advances N minutes.

## Timing
- Latency is one cycle for both load and tick. The input is sampled at edge k and the new value is visible after edge k.
- `day_wrap` and `load_err` are asserted in the same cycle as the digit update they belong to.
- Reset asserted mid-operation (including during a load or tick cycle) forces 00:00 at that edge. Pending inputs are ignored.
- No handshake: `load_new_c` is level-sampled, one load per high cycle. Holding it high reloads the same value every cycle, which blocks ticks.
- No combinational path from any input to any output.

## Structure
- Shared package `aclk_pkg` holds:
  - the BCD digit width constant (4);
  - digit limits: `MAX_LS = 9`, `MAX_MS_MIN = 5`, `MAX_MS_HR = 2`, `MAX_LS_HR_AT_20 = 3`;
  - a `time_valid` function, reused by the alarm-set path.
- One sub-module is natural: `aclk_bcd_inc`, a combinational next-time incrementer. It takes HH:MM, returns HH:MM + 1 minute and a wrap flag.
- The top level holds the four digit registers, the priority mux and the pulse flags.

## Test plan
- Reset low for one edge, then release → outputs 00:00, `day_wrap` = 0, `load_err` = 0.
- Load 12:59, then one tick → 13:00. Load 09:59, then one tick → 10:00. Each step takes effect one cycle after the edge.
- Load 23:58, then two ticks → 23:59, then 00:00 with `day_wrap` = 1 for exactly one cycle.
- Invalid loads 24:00, 19:60 and 0A:00 (hours tens digit 0x0, hours units digit 0xA), each applied with the time held at 11:11 → time stays 11:11 and `load_err` pulses once per request.
- `load_new_c` (value 07:30) and `one_minute` high in the same cycle → 07:30, not 07:31. Reset asserted together with a load → 00:00.
- With `aclk_timegen` (fastwatch) as the tick source, starting at 00:00, run 1440 ticks → back to 00:00 with exactly one `day_wrap`. A scoreboard confirms every digit stays within its legal range on every cycle.
